// File: rtl/zs_thin_unit_if.sv
// Pixel stream interface for zs_thin_unit: input load stream and result stream.
// The unit connects through the slave modport, the producer/consumer side through master.
interface zs_thin_unit_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 7
) ();
    logic              in_valid;
    logic [PIX_W-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/zs_thin_unit.sv
// Zhang-Suen thinning sub-iteration unit: buffers one binary image and streams one pass out.
// Optional ZS_DEL_COUNT_EN adds a saturating per-pass deleted-pixel counter (del_count).
module zs_thin_unit #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_load,
    input  logic          start_proc,
    input  logic          sub_sel,
    zs_thin_unit_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic          changed
`ifdef ZS_DEL_COUNT_EN
    ,
    output logic [ADDR_W:0] del_count
`endif
);

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned IW   = $clog2(NPIX);
    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] WOFF = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {StIdle, StLoad, StProc, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              sub_q, sub_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [PIX_W-1:0]  out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_del_q, out_del_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              changed_q, changed_d;
`ifdef ZS_DEL_COUNT_EN
    logic [ADDR_W:0]   del_cnt_q, del_cnt_d;
`endif

    logic [PIX_W-1:0]  mem_q [NPIX];
    logic [ADDR_W-1:0] naddr [8];
    logic [7:0]        nb;
    logic [3:0]        b_cnt, a_cnt;
    logic              border, shape_ok, del, wr_en, hs;

    assign wr_en = rst_n && (state_q == StLoad) && bus.in_valid && in_ready_q;
    assign hs    = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wcnt_q[IW-1:0]] <= bus.in_data;
        end
    end

    // Neighbours N, NE, E, SE, S, SW, W, NW; out-of-range reads (border only) are ignored.
    always_comb begin
        naddr[0] = rcnt_q - WOFF;
        naddr[1] = rcnt_q - WOFF + ADDR_W'(1);
        naddr[2] = rcnt_q + ADDR_W'(1);
        naddr[3] = rcnt_q + WOFF + ADDR_W'(1);
        naddr[4] = rcnt_q + WOFF;
        naddr[5] = rcnt_q + WOFF - ADDR_W'(1);
        naddr[6] = rcnt_q - ADDR_W'(1);
        naddr[7] = rcnt_q - WOFF - ADDR_W'(1);
        nb    = '0;
        b_cnt = '0;
        a_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            nb[i] = ({1'b0, naddr[i]} < (ADDR_W + 1)'(NPIX)) && (|mem_q[naddr[i][IW-1:0]]);
        end
        for (int i = 0; i < 8; i++) begin
            b_cnt = b_cnt + 4'(nb[i]);
            a_cnt = a_cnt + 4'(!nb[i] && nb[(i + 1) % 8]);
        end
        border = (row_q == '0) || (row_q == RW'(IMG_H - 1)) ||
                 (col_q == '0) || (col_q == CW'(IMG_W - 1));
        if (sub_q) begin
            shape_ok = !(nb[0] && nb[2] && nb[6]) && !(nb[0] && nb[4] && nb[6]);
        end else begin
            shape_ok = !(nb[0] && nb[2] && nb[4]) && !(nb[2] && nb[4] && nb[6]);
        end
        del = !border && (|mem_q[rcnt_q[IW-1:0]]) && (b_cnt >= 4'd2) && (b_cnt <= 4'd6) &&
              (a_cnt == 4'd1) && shape_ok;
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        col_d       = col_q;
        row_d       = row_q;
        sub_d       = sub_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_del_d   = out_del_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        changed_d   = changed_q;
`ifdef ZS_DEL_COUNT_EN
        del_cnt_d   = del_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_load || start_proc) begin
                    state_d    = start_load ? StLoad : StProc;
                    in_ready_d = start_load;
                    wcnt_d     = '0;
                    rcnt_d     = '0;
                    col_d      = '0;
                    row_d      = '0;
                    sub_d      = sub_sel;
                    busy_d     = 1'b1;
                    changed_d  = 1'b0;
`ifdef ZS_DEL_COUNT_EN
                    del_cnt_d  = '0;
`endif
                end
            end
            StLoad: begin
                if (bus.in_valid && in_ready_q) begin
                    wcnt_d = wcnt_q + ADDR_W'(1);
                    if (wcnt_q == LAST) begin
                        state_d    = StProc;
                        in_ready_d = 1'b0;
                    end
                end
            end
            StProc: begin
                if (hs && out_del_q) begin
                    changed_d = 1'b1;
`ifdef ZS_DEL_COUNT_EN
                    if (del_cnt_q != (ADDR_W + 1)'(NPIX)) begin
                        del_cnt_d = del_cnt_q + (ADDR_W + 1)'(1);
                    end
`endif
                end
                if (hs && (out_addr_q == LAST)) begin
                    state_d     = StDone;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else if (!out_valid_q || bus.out_ready) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = rcnt_q;
                    out_del_d   = del;
                    out_data_d  = del ? '0 : mem_q[rcnt_q[IW-1:0]];
                    rcnt_d      = rcnt_q + ADDR_W'(1);
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            sub_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_del_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            changed_q   <= 1'b0;
`ifdef ZS_DEL_COUNT_EN
            del_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sub_q       <= sub_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_del_q   <= out_del_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            changed_q   <= changed_d;
`ifdef ZS_DEL_COUNT_EN
            del_cnt_q   <= del_cnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign changed       = changed_q;
`ifdef ZS_DEL_COUNT_EN
    assign del_count     = del_cnt_q;
`endif

endmodule

// File: tb/tb_zs_thin_unit.sv
// Directed bench for zs_thin_unit on a 5x5 image with hand-computed expected pass results.
module tb_zs_thin_unit;
    localparam int unsigned IMG_W  = 5;
    localparam int unsigned IMG_H  = 5;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int NPIX = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_load = 1'b0;
    logic start_proc = 1'b0;
    logic sub_sel = 1'b0;
    logic busy, done, changed;
`ifdef ZS_DEL_COUNT_EN
    logic [ADDR_W:0] del_count;
`endif

    zs_thin_unit_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    zs_thin_unit #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_load(start_load),
        .start_proc(start_proc),
        .sub_sel   (sub_sel),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .changed   (changed)
`ifdef ZS_DEL_COUNT_EN
        ,
        .del_count (del_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] cur_img [NPIX];
    logic [7:0] cur_exp [NPIX];
    logic [3:0] stall_pat = 4'b1001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] img_v, input logic [7:0] exp_v);
        for (int i = 0; i < NPIX; i++) begin
            cur_img[i] = img_v;
            cur_exp[i] = exp_v;
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 with the unit in PROC.
    task automatic load_image(input logic both, input logic sub);
        int  k;
        int  cyc;
        logic rdy;
        logic v;
        k = 0;
        cyc = 0;
        start_load = 1'b1;
        start_proc = both;
        sub_sel = sub;
        @(posedge clk); #1;
        start_load = 1'b0;
        start_proc = 1'b0;
        sub_sel = ~sub;
        check("load_in_ready", bus.in_ready, 1);
        check("load_busy", busy, 1);
        while (k < NPIX && cyc < 200) begin
            rdy = bus.in_ready;
            v = (cyc % 7 != 3);
            bus.in_valid = v;
            bus.in_data = cur_img[k];
            @(posedge clk); #1;
            cyc++;
            if (rdy && v) k++;
        end
        bus.in_valid = 1'b0;
        check("load_count", k, NPIX);
        check("load_end_in_ready", bus.in_ready, 0);
        check("load_end_busy", busy, 1);
    endtask

    // Called at posedge+1 right after PROC entry.
    task automatic run_pass(input logic stall, input logic exp_chg, input int exp_del);
        int   nhs;
        int   vcyc;
        int   cyc;
        int   ndel;
        logic r;
        logic got_done;
        logic saw_rdy;
        nhs = 0;
        vcyc = 0;
        cyc = 0;
        ndel = 0;
        got_done = 1'b0;
        saw_rdy = 1'b0;
        check("first_cycle_valid", bus.out_valid, 0);
        while (cyc < 400) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.in_ready) saw_rdy = 1'b1;
            start_load = stall && (cyc == 3);
            r = stall ? stall_pat[cyc % 4] : 1'b1;
            bus.out_ready = r;
            if (bus.out_valid) begin
                vcyc++;
                if (nhs < NPIX) begin
                    check("out_addr", bus.out_addr, nhs);
                    check("out_data", bus.out_data, cur_exp[nhs]);
                    if (r) begin
                        if (cur_img[nhs] != 8'h00 && bus.out_data == 8'h00) ndel++;
                        nhs++;
                    end
                end else begin
                    check("extra_valid", bus.out_valid, 0);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_load = 1'b0;
        bus.out_ready = 1'b1;
        check("done_seen", got_done, 1);
        check("handshakes", nhs, NPIX);
        check("deleted_seen", ndel, exp_del);
        check("done_out_valid", bus.out_valid, 0);
        check("done_changed", changed, exp_chg);
        check("no_in_ready", saw_rdy, 0);
        if (!stall) check("valid_cycles", vcyc, NPIX);
`ifdef ZS_DEL_COUNT_EN
        check("del_count", del_count, exp_del);
`endif
        @(posedge clk); #1;
        check("done_pulse_end", done, 0);
        check("idle_busy", busy, 0);
        check("changed_hold", changed, exp_chg);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_changed", changed, 0);
        rst_n = 1'b1;

        // 3x3 block at rows/cols 1..3, first sub-iteration.
        fill(8'h00, 8'h00);
        cur_img[6] = 8'hFF;  cur_img[7] = 8'hFF;  cur_img[8] = 8'hFF;
        cur_img[11] = 8'hFF; cur_img[12] = 8'hFF; cur_img[13] = 8'hFF;
        cur_img[16] = 8'hFF; cur_img[17] = 8'hFF; cur_img[18] = 8'hFF;
        cur_exp[7] = 8'hFF;  cur_exp[11] = 8'hFF; cur_exp[12] = 8'hFF;
        load_image(1'b0, 1'b0);
        run_pass(1'b0, 1'b1, 6);

        // Same buffer, second sub-iteration, stalled output.
        for (int i = 0; i < NPIX; i++) cur_exp[i] = 8'h00;
        cur_exp[12] = 8'hFF; cur_exp[13] = 8'hFF; cur_exp[17] = 8'hFF;
        start_proc = 1'b1;
        sub_sel = 1'b1;
        @(posedge clk); #1;
        start_proc = 1'b0;
        sub_sel = 1'b0;
        check("proc_busy", busy, 1);
        check("proc_in_ready", bus.in_ready, 0);
        run_pass(1'b1, 1'b1, 6);

        // Single pixel; both start pulses together must take LOAD.
        fill(8'h00, 8'h00);
        cur_img[12] = 8'hFF;
        cur_exp[12] = 8'hFF;
        load_image(1'b1, 1'b0);
        run_pass(1'b0, 1'b0, 0);

        // Partial load aborted by reset.
        start_load = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h5A;
        repeat (10) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_busy", busy, 0);

        // All-foreground image: borders pass, interior B=8 keeps everything.
        fill(8'hFF, 8'hFF);
        load_image(1'b0, 1'b0);
        run_pass(1'b1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zs_thin_unit.md
Name: zs_thin_unit

Overview:
- Parametrised successor to the fixed N x N convolutional mask unit.
- Buffers one IMG_W x IMG_H binary image and streams one Zhang-Suen thinning sub-iteration result back out.
- Handles border padding, both sub-iteration modes, valid/ready backpressure on input and output, and a per-pass "changed" flag for the outer iteration controller.
- Sits between the image RAM loader and the skeletonization iteration controller.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- PIX_W, 8, pixel data width; nonzero = foreground
- ADDR_W, 7, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start_load  in  1  pulse in IDLE: load a new image, then process
- start_proc  in  1  pulse in IDLE: process the already-buffered image
- sub_sel  in  1  sub-iteration select, sampled on the start pulse (0 = first, 1 = second)
- in_valid  in  1  input pixel valid
- in_data  in  PIX_W  input pixel, raster order
- in_ready  out  1  unit accepts a pixel
- out_valid  out  1  result pixel valid
- out_ready  in  1  downstream accepts the result
- out_data  out  PIX_W  result pixel
- out_addr  out  ADDR_W  raster address of out_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of pass
- changed  out  1  at least one pixel deleted in the last pass

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; all counters=0.
  - in_ready=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, changed=0.
  - Buffer contents are undefined after reset.
- FSM states: IDLE, LOAD, PROC, DONE.
- IDLE:
  - start_load -> LOAD. start_proc -> PROC.
  - Both high in the same cycle: start_load wins.
  - sub_sel is latched on the start pulse.
  - changed is cleared on entering LOAD or PROC.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready cycle writes in_data to buffer[wcnt] and increments wcnt.
  - Accepting pixel IMG_W*IMG_H-1 -> PROC next cycle, with in_ready=0 from that cycle.
  - Start pulses are ignored while not in IDLE.
- PROC:
  - Raster counter rcnt, plus row/col counters; no division.
  - Result for rcnt is registered. out_valid rises the cycle after entering PROC.
  - While out_valid=1 and out_ready=0: out_data and out_addr are held stable, counters frozen.
  - A handshake advances to the next address. The handshake on address IMG_W*IMG_H-1 -> DONE.
  - All reads come from the unmodified buffer; results are not written back during the pass.
- Pixel rule:
  - Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) pass through unchanged.
  - Interior pixels: P1 = centre; P2..P9 = N, NE, E, SE, S, SW, W, NW; each is 1 if nonzero.
  - B = count of P2..P9 that are 1 (4-bit).
  - A = number of 0->1 transitions in the sequence P2..P9,P2.
  - Delete when P1=1 and 2<=B<=6 and A==1, plus:
    - sub_sel=0: P2&P4&P6==0 and P4&P6&P8==0
    - sub_sel=1: P2&P4&P8==0 and P2&P6&P8==0
  - Deleted pixel: out_data=0 and changed is set (sticky for the pass). Otherwise out_data = original pixel.
- DONE:
  - done=1 for exactly one cycle, out_valid=0 -> IDLE.
  - changed holds until the next start.
- Reset mid-operation returns to IDLE immediately; a partial load or pass is discarded.
- Latency: first result 1 cycle after PROC entry. Throughput is 1 pixel/cycle with out_ready held high.

Optional Feature:
- Macro: ZS_DEL_COUNT_EN.
- Defined:
  - Adds output del_count [ADDR_W:0], the number of pixels deleted in the current pass.
  - Cleared on a start pulse; incremented on each handshake of a deleted pixel.
  - Saturates at IMG_W*IMG_H; reset value 0.
- Undefined: port and counter are absent. changed behaviour is identical either way.

Test Plan:
- Test config is IMG_W=IMG_H=5, PIX_W=8.
- Load 3x3 block of 0xFF at rows/cols 1..3, sub_sel=0, out_ready=1 -> addr 6 (1,1) out 0x00, addr 12 (2,2) out 0xFF, changed=1 at done, 25 results in 25 consecutive cycles.
- Single 0xFF at addr 12 -> passes unchanged (B=0), changed=0; del_count=0 if ZS_DEL_COUNT_EN.
- All-0xFF image -> borders addr 0..4, 20..24, 5, 10, 15, 9, 14, 19 pass 0xFF unchanged; interior B=8, no deletes.
- Toggle out_ready 1,0,0,1 repeatedly -> out_data/out_addr stable during stalls, no address skipped or repeated, done after 25 handshakes.
- After a pass, start_proc with sub_sel=1 -> same buffer reprocessed, no in_ready assertion. Assert start_load and start_proc together -> LOAD taken.
- Drop rst_n for one cycle during LOAD after 10 pixels -> IDLE, in_ready=0, busy=0. Next start_load requires a full 25 pixels.
